etaj_decodificare: RTL
======================

// Module: etaj_decodificare
// PURPOSE
//  Parametrised, pipelined instruction-decode stage for the RISC-8 core, between fetch and register read.
//  Splits each instruction into opcode/rs/rt/rd/immediate and extends the immediate to DATA_W bits.
//  Flags illegal opcodes and buffers instructions behind a valid/ready handshake (2-entry skid, no bubbles).
//  Counts decoded instructions. Defaults reproduce the 16-bit 4/4/4/4 format with an 8-bit immediate.
// PARAMETERS
//  INSTR_W    16       instruction width; must equal OPCODE_W + 3*REG_W
//  OPCODE_W   4        opcode field width, field at instr[INSTR_W-1 -: OPCODE_W]
//  REG_W      4        register field width; rs, rt and rd follow the opcode MSB->LSB (rd = instr[REG_W-1:0])
//  IMM_W      8        immediate width, field at instr[IMM_W-1:0]; IMM_W <= INSTR_W-OPCODE_W-REG_W
//  DATA_W     16       width of imm_ext; must be >= IMM_W
//  PC_W       8        program-counter width, carried alongside the instruction
//  SEXT_MASK  16'h0000 bit k=1: opcode k sign-extends its immediate; bit k=0: zero-extends
//  LEGAL_MASK 16'hFFFF bit k=1: opcode k legal (2**OPCODE_W bits)
//  COUNT_W    16       width of decode counter
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  flush      in   1         synchronous pipeline flush
//  in_valid   in   1         fetch offers an instruction
//  in_ready   out  1         stage can accept (registered)
//  instr      in   INSTR_W   instruction word
//  pc_in      in   PC_W      address of instr
//  out_valid  out  1         decoded fields valid
//  out_ready  in   1         register-read stage accepts
//  opcode     out  OPCODE_W  decoded opcode
//  rs,rt,rd   out  REG_W     decoded register indices (three ports)
//  imm_raw    out  IMM_W     raw immediate field
//  imm_ext    out  DATA_W    immediate sign- or zero-extended per SEXT_MASK[opcode]
//  illegal    out  1         LEGAL_MASK[opcode]==0; instruction still passed downstream
//  pc_out     out  PC_W      pc of presented instruction
//  dec_count  out  COUNT_W   number of output handshakes, wraps modulo 2**COUNT_W
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, all data outputs and dec_count=0, both entries empty.
//  Reset applied mid-operation discards both entries immediately.
//  Accept on in_valid&in_ready; emit on out_valid&out_ready. Decode is combinational on the input word.
//  Decoded fields are stored in the entry, so outputs come straight from flops.
//  Latency 1 clk: an instruction accepted at edge N is on the outputs after edge N.
//  Outputs hold stable while out_valid=1 and out_ready=0.
//  States: EMPTY(0 entries), ONE(main valid), FULL(main+skid valid); in_ready=1 in EMPTY/ONE, 0 in FULL.
//   EMPTY: accept -> ONE.
//   ONE: accept without emit -> FULL (word goes to skid). Emit without accept -> EMPTY.
//    Accept and emit together -> ONE (new word loads main).
//   FULL: emit -> ONE (skid moves to main, skid cleared). No emit -> FULL.
//  Simultaneous accept+emit in ONE gives 1 instr/clk throughput with no bubble.
//  Order is preserved: skid is never presented before main.
//  flush=1 at an edge: next state EMPTY, in_ready=1, out_valid=0. That cycle's in_valid is ignored.
//   A handshake in the flush cycle still counts toward dec_count.
//  dec_count increments by 1 per output handshake and wraps from all-ones to 0.
//  Extension: SEXT_MASK[op] ? {{(DATA_W-IMM_W){imm[IMM_W-1]}},imm} : zero-padded. DATA_W==IMM_W -> pass-through.
//  illegal depends only on opcode; it never blocks the handshake.
// TESTING
//  1 Reset, then instr=16'h1234, pc 8'h00, out_ready=1 -> next clk: opcode=1, rs=2, rt=3, rd=4, imm_raw=8'h34, imm_ext=16'h0034.
//  2 SEXT_MASK=16'h0002, instr=16'h1A80 -> imm_ext=16'hFF80. Same word with SEXT_MASK=0 -> 16'h0080.
//  3 Stream 3 words, out_ready=0 -> in_ready drops after 2nd accept, 3rd held off.
//    Raise out_ready -> words emitted in order, 1/clk, no loss.
//  4 Continuous in_valid=out_ready=1 for 20 clks -> 20 outputs in 20 clks after 1-clk fill; dec_count=20.
//  5 FULL state, assert flush with in_valid=1 -> next clk out_valid=0, in_ready=1, flush-cycle word dropped.
//  6 LEGAL_MASK=16'h7FFF, instr=16'hF000 -> illegal=1, still emitted. Async rst mid-stream -> outputs 0 at once, dec_count=0.

Source files
------------

// File: rtl/etaj_decodificare.sv
// Pipelined decode stage: splits an instruction into fields, extends the immediate,
// flags illegal opcodes and buffers results in a two-entry skid buffer.
module etaj_decodificare #(
    parameter int                      INSTR_W    = 16,
    parameter int                      OPCODE_W   = 4,
    parameter int                      REG_W      = 4,
    parameter int                      IMM_W      = 8,
    parameter int                      DATA_W     = 16,
    parameter int                      PC_W       = 8,
    parameter logic [2**OPCODE_W-1:0]  SEXT_MASK  = '0,
    parameter logic [2**OPCODE_W-1:0]  LEGAL_MASK = '1,
    parameter int                      COUNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [PC_W-1:0]     pc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [IMM_W-1:0]    imm_raw,
    output logic [DATA_W-1:0]   imm_ext,
    output logic                illegal,
    output logic [PC_W-1:0]     pc_out,
    output logic [COUNT_W-1:0]  dec_count
);

    localparam int ENT_W = OPCODE_W + 3*REG_W + IMM_W + DATA_W + 1 + PC_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic [OPCODE_W-1:0] dec_op;
    logic [REG_W-1:0]    dec_rs;
    logic [REG_W-1:0]    dec_rt;
    logic [REG_W-1:0]    dec_rd;
    logic [IMM_W-1:0]    dec_imm;
    logic [DATA_W-1:0]   dec_ext;
    logic                dec_ill;
    logic                dec_sext;
    logic [ENT_W-1:0]    dec_entry;

    assign dec_op   = instr[INSTR_W-1 -: OPCODE_W];
    assign dec_rs   = instr[INSTR_W-OPCODE_W-1 -: REG_W];
    assign dec_rt   = instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
    assign dec_rd   = instr[REG_W-1:0];
    assign dec_imm  = instr[IMM_W-1:0];
    assign dec_sext = SEXT_MASK[dec_op];
    assign dec_ill  = ~LEGAL_MASK[dec_op];

    // Bits above IMM_W replicate the sign bit or stay zero; DATA_W==IMM_W degenerates to a copy.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            if (gi < IMM_W) begin : g_low
                assign dec_ext[gi] = dec_imm[gi];
            end else begin : g_high
                assign dec_ext[gi] = dec_sext & dec_imm[IMM_W-1];
            end
        end
    endgenerate

    assign dec_entry = {dec_op, dec_rs, dec_rt, dec_rd, dec_imm, dec_ext, dec_ill, pc_in};

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    main_q, main_d;
    logic [ENT_W-1:0]    skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                accept;
    logic                emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q + COUNT_W'(emit);
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = dec_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    main_d = dec_entry;
                end else if (accept) begin
                    skid_d  = dec_entry;
                    state_d = ST_FULL;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards both entries; a handshake in this cycle is still counted above.
        if (flush) begin
            state_d = ST_EMPTY;
            skid_d  = '0;
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign {opcode, rs, rt, rd, imm_raw, imm_ext, illegal, pc_out} = main_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dec_count = count_q;

endmodule
